down_counter_timer: RTL and testbench

Programmable countdown timer; the down-counting counterpart to the team's free-running up counter.
- Loads a start value and decrements once per prescaled tick.
- Flags expiry with a one-cycle pulse, then either stops or auto-reloads.
- Sits beside the up counter in the timing/sequencing fabric, generating timeouts and periodic strobes for downstream control logic.

---
 rtl/down_counter_timer_pkg.sv | 17 +
 rtl/down_counter_timer_tick_prescaler.sv | 45 ++++
 rtl/down_counter_timer.sv | 132 +++++++++++++
 tb/tb_down_counter_timer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/down_counter_timer_pkg.sv
// Shared definitions for the countdown timer.
// Holds the FSM state encoding and the default parameter values used by
// down_counter_timer and its tick_prescaler.
package down_counter_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSED,
        ST_DONE
    } timer_state_e;

    localparam int unsigned DEFAULT_W        = 4;
    localparam int unsigned DEFAULT_PRESCALE = 1;
    localparam int unsigned DEFAULT_PW       = 8;

endpackage

// File: rtl/down_counter_timer_tick_prescaler.sv
// tick_prescaler: divides the clock into decrement ticks.
//   clk     - clock, posedge
//   reset   - synchronous, active-low
//   clear   - force the prescaler counter back to 0 (wins over enable)
//   enable  - advance the prescaler this cycle
//   tick    - high while the counter sits at PRESCALE-1; the counter wraps to
//             0 on the next enabled edge. Consumers gate it with their own
//             enable condition.
module tick_prescaler
    import down_counter_timer_pkg::*;
#(
    parameter int unsigned PRESCALE = DEFAULT_PRESCALE,
    parameter int unsigned PW       = DEFAULT_PW
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/down_counter_timer.sv
// down_counter_timer: programmable countdown timer with one-shot or
// auto-reload operation.
//   clk          - clock, posedge
//   reset        - synchronous, active-low
//   load         - capture load_value into count and reload register
//   load_value   - value to load (W bits)
//   start        - begin countdown from IDLE or DONE
//   pause        - level, freezes an active countdown
//   auto_reload  - level, 1 = periodic, 0 = one-shot (sampled at expiry)
//   count        - current count (registered)
//   expired      - one-cycle pulse per expiry (registered)
//   busy         - high in RUN or PAUSED (registered)
module down_counter_timer
    import down_counter_timer_pkg::*;
#(
    parameter int unsigned W        = DEFAULT_W,
    parameter int unsigned PRESCALE = DEFAULT_PRESCALE,
    parameter int unsigned PW       = DEFAULT_PW
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         start,
    input  logic         pause,
    input  logic         auto_reload,
    output logic [W-1:0] count,
    output logic         expired,
    output logic         busy
);

    timer_state_e state_q, state_d;
    logic [W-1:0] count_q, count_d;
    logic [W-1:0] reload_q, reload_d;
    logic         expired_q, expired_d;
    logic         busy_q, busy_d;

    logic [W-1:0] start_val;
    logic         presc_clear;
    logic         presc_enable;
    logic         tick;

    tick_prescaler #(
        .PRESCALE (PRESCALE),
        .PW       (PW)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .clear  (presc_clear),
        .enable (presc_enable),
        .tick   (tick)
    );

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        reload_d     = reload_q;
        expired_d    = 1'b0;
        presc_clear  = 1'b0;
        presc_enable = 1'b0;
        start_val    = (state_q == ST_DONE) ? reload_q : count_q;

        if (load) begin
            reload_d    = load_value;
            count_d     = load_value;
            presc_clear = 1'b1;
            state_d     = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        count_d = start_val;
                        if (start_val != '0) begin
                            state_d     = ST_RUN;
                            presc_clear = 1'b1;
                        end else begin
                            expired_d = 1'b1;
                            state_d   = ST_DONE;
                        end
                    end
                end
                ST_RUN, ST_PAUSED: begin
                    // The edge that releases pause counts as a running edge,
                    // so a pause of N cycles delays expiry by exactly N.
                    if (pause) begin
                        state_d = ST_PAUSED;
                    end else begin
                        state_d      = ST_RUN;
                        presc_enable = 1'b1;
                        if (tick) begin
                            if (count_q > W'(1)) begin
                                count_d = count_q - 1'b1;
                            end else begin
                                expired_d = 1'b1;
                                if (auto_reload) begin
                                    count_d = reload_q;
                                end else begin
                                    count_d = '0;
                                    state_d = ST_DONE;
                                end
                            end
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        busy_d = (state_d == ST_RUN) || (state_d == ST_PAUSED);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            reload_q  <= '0;
            expired_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            reload_q  <= reload_d;
            expired_q <= expired_d;
            busy_q    <= busy_d;
        end
    end

    assign count   = count_q;
    assign expired = expired_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_down_counter_timer.sv
// Testbench for down_counter_timer: two instances (PRESCALE 1 and 3) share
// the same stimulus and are checked every cycle against a behavioural model
// that tracks remaining cycles-to-tick and an active/done view of the timer.
module tb_down_counter_timer;

    logic       clk = 1'b0;
    logic       reset;
    logic       load;
    logic [3:0] load_value;
    logic       start;
    logic       pause;
    logic       auto_reload;

    logic [3:0] count0, count1;
    logic       expired0, expired1;
    logic       busy0, busy1;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;

    // Behavioural model state, one entry per instance.
    int m_count  [2];
    int m_reload [2];
    int m_left   [2];   // clock edges remaining until next decrement tick
    bit m_active [2];   // countdown in progress (running or paused)
    bit m_done   [2];   // finished; next start re-arms from the reload value
    bit m_exp    [2];
    int presc    [2] = '{1, 3};

    always #5 clk = ~clk;

    down_counter_timer #(.W(4), .PRESCALE(1), .PW(8)) dut0 (
        .clk(clk), .reset(reset), .load(load), .load_value(load_value),
        .start(start), .pause(pause), .auto_reload(auto_reload),
        .count(count0), .expired(expired0), .busy(busy0)
    );

    down_counter_timer #(.W(4), .PRESCALE(3), .PW(8)) dut1 (
        .clk(clk), .reset(reset), .load(load), .load_value(load_value),
        .start(start), .pause(pause), .auto_reload(auto_reload),
        .count(count1), .expired(expired1), .busy(busy1)
    );

    task automatic check_eq(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            failures++;
            $display("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cycle, observed, expected);
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            m_exp[i] = 1'b0;
            if (!reset) begin
                m_count[i]  = 0;
                m_reload[i] = 0;
                m_active[i] = 1'b0;
                m_done[i]   = 1'b0;
                m_left[i]   = presc[i];
            end else if (load) begin
                m_count[i]  = load_value;
                m_reload[i] = load_value;
                m_active[i] = 1'b0;
                m_done[i]   = 1'b0;
                m_left[i]   = presc[i];
            end else if (!m_active[i]) begin
                if (start) begin
                    int v;
                    v = m_done[i] ? m_reload[i] : m_count[i];
                    m_count[i] = v;
                    if (v != 0) begin
                        m_active[i] = 1'b1;
                        m_done[i]   = 1'b0;
                        m_left[i]   = presc[i];
                    end else begin
                        m_exp[i]  = 1'b1;
                        m_done[i] = 1'b1;
                    end
                end
            end else if (!pause) begin
                m_left[i]--;
                if (m_left[i] == 0) begin
                    m_left[i] = presc[i];
                    if (m_count[i] > 1) begin
                        m_count[i]--;
                    end else begin
                        m_exp[i] = 1'b1;
                        if (auto_reload) begin
                            m_count[i] = m_reload[i];
                        end else begin
                            m_count[i]  = 0;
                            m_active[i] = 1'b0;
                            m_done[i]   = 1'b1;
                        end
                    end
                end
            end
        end
    endtask

    task automatic compare_all();
        check_eq("count_p1",   int'(count0),   m_count[0]);
        check_eq("expired_p1", int'(expired0), int'(m_exp[0]));
        check_eq("busy_p1",    int'(busy0),    int'(m_active[0]));
        check_eq("count_p3",   int'(count1),   m_count[1]);
        check_eq("expired_p3", int'(expired1), int'(m_exp[1]));
        check_eq("busy_p3",    int'(busy1),    int'(m_active[1]));
    endtask

    // Apply one set of inputs for one edge, advance the model, then compare.
    task automatic step(input bit r, input bit l, input int lv, input bit s,
                        input bit p, input bit a);
        reset       = r;
        load        = l;
        load_value  = lv[3:0];
        start       = s;
        pause       = p;
        auto_reload = a;
        @(posedge clk);
        model_edge();
        cycle++;
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle_cycles(input int n, input bit p, input bit a);
        for (int k = 0; k < n; k++) step(1, 0, 0, 0, p, a);
    endtask

    initial begin
        reset = 1'b0; load = 1'b0; load_value = '0;
        start = 1'b0; pause = 1'b0; auto_reload = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_count[i] = 0; m_reload[i] = 0; m_left[i] = presc[i];
            m_active[i] = 0; m_done[i] = 0; m_exp[i] = 0;
        end
        @(negedge clk);

        // Reset state, then reset asserted mid-countdown.
        step(0, 0, 0, 0, 0, 0);
        step(1, 1, 9, 0, 0, 0);
        step(1, 0, 0, 1, 0, 0);
        idle_cycles(3, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        idle_cycles(2, 0, 0);

        // One-shot countdown from 5.
        step(1, 1, 5, 0, 0, 0);
        step(1, 0, 0, 1, 0, 0);
        idle_cycles(18, 0, 0);

        // Auto-reload with reload value 2.
        step(1, 1, 2, 0, 0, 1);
        step(1, 0, 0, 1, 0, 1);
        idle_cycles(20, 0, 1);

        // Pause for 10 cycles mid-countdown, including across a tick.
        step(1, 1, 8, 0, 0, 0);
        step(1, 0, 0, 1, 0, 0);
        idle_cycles(3, 0, 0);
        idle_cycles(10, 1, 0);
        idle_cycles(30, 0, 0);

        // Zero load then start; start again from DONE with zero reload.
        step(1, 1, 0, 0, 0, 0);
        step(1, 0, 0, 1, 0, 0);
        idle_cycles(2, 0, 0);
        step(1, 0, 0, 1, 1, 0);
        idle_cycles(2, 0, 0);

        // Maximum load, no wrap below zero; then restart from DONE.
        step(1, 1, 15, 0, 0, 0);
        step(1, 0, 0, 1, 0, 0);
        idle_cycles(50, 0, 0);
        step(1, 0, 0, 1, 0, 0);
        idle_cycles(6, 0, 0);

        // Collisions: load+start, start while running, load mid-run.
        step(1, 1, 3, 1, 0, 0);
        idle_cycles(2, 0, 0);
        step(1, 0, 0, 1, 0, 0);
        step(1, 0, 0, 1, 0, 0);
        step(1, 1, 7, 0, 0, 0);
        idle_cycles(3, 0, 0);

        // Randomized stimulus.
        begin
            bit p_lvl = 0;
            bit a_lvl = 0;
            for (int n = 0; n < 4000; n++) begin
                bit r, l, s;
                int lv;
                int sel;
                r = ($urandom_range(0, 199) != 0);
                l = ($urandom_range(0, 39) == 0);
                s = ($urandom_range(0, 11) == 0);
                if ($urandom_range(0, 15) == 0) p_lvl = ~p_lvl;
                if ($urandom_range(0, 63) == 0) a_lvl = ~a_lvl;
                sel = $urandom_range(0, 9);
                if (sel == 0)      lv = 0;
                else if (sel == 1) lv = 15;
                else if (sel < 6)  lv = $urandom_range(1, 3);
                else               lv = $urandom_range(0, 15);
                step(r, l, lv, s, p_lvl, a_lvl);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
